// File: rtl/div_seq.sv
// Sequential signed restoring divider: WIDTH-cycle shift/subtract on magnitudes, then sign fix-up.
// Optional `DIV_ZERO_CHK_EN` short-circuits a zero divisor straight to DONE with div_zero set.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr_mag;
  logic             neg_q;
  logic             neg_r;
  logic             accept;
  logic             zero_div;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef DIV_ZERO_CHK_EN
  assign zero_div = accept && (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Magnitude of the most negative value wraps to itself, which reads
  // correctly as 2^(WIDTH-1) in an unsigned register.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = (state == CALC) || (state == FIX);
    done      = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = zero_div ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dsr_mag   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        rem     <= '0;
        quo     <= mag(dividend);
        dsr_mag <= mag(divisor);
        neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r   <= dividend[WIDTH-1];
        if (zero_div) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        // Non-negative trial keeps the difference; otherwise restore.
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else if (state == FIX) begin
        quotient  <= neg_q ? -quo : quo;
        remainder <= neg_r ? -rem : rem;
      end
    end
  end

`ifdef DIV_ZERO_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_zero <= 1'b0;
    else if (zero_div)       div_zero <= 1'b1;
    else if (state == FIX)   div_zero <= 1'b0;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed steps, scoreboard queue of expected results.
// Works with or without DIV_ZERO_CHK_EN defined.
module tb_div_seq;

  localparam int W = 32;

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  // Reference model: language-level signed division plus the two special cases.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dz  = 1'b0;
    e.lat = W + 2;
    if (b == '0) begin
      e.r = a;
      if (ZCHK) begin
        e.q = '1; e.dz = 1'b1; e.lat = 1;
      end else begin
        e.q = a[W-1] ? W'(1) : '1;
      end
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a; e.r = '0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, checking busy and latency; returns at the DONE-cycle negedge.
  // A nonzero poke re-pulses start with 9/2 in that cycle and then scrambles operands.
  task automatic wait_result(input string tag, input int poke);
    int   cyc;
    bit   busy_ok;
    exp_t e;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke != 0 && cyc == poke) begin
        start = 1'b1; dividend = 9; divisor = 2;
      end else if (poke != 0 && cyc > poke) begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s_scoreboard: observed done expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, cyc, e.lat);
      check({tag, "_busy_during"}, busy_ok, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_div_zero"}, div_zero, e.dz);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           n_done;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_div_zero", div_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(100, 7, mk(14, 2, 1'b0, 34));
    wait_result("p100_d7", 0);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("quotient_hold", quotient, 14);

    issue(-100, 7, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34));
    wait_result("m100_d7", 0);
    issue(100, -7, mk(32'hFFFF_FFF2, 2, 1'b0, 34));
    wait_result("p100_dm7", 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 0, 1'b0, 34));
    wait_result("min_dm1", 0);
    issue(5, 0, mk(32'hFFFF_FFFF, 5, ZCHK, ZCHK ? 1 : 34));
    wait_result("p5_d0", 0);
    issue(-5, 0, model(-5, 0));
    wait_result("m5_d0", 0);
    issue(7, 32'h8000_0000, mk(0, 7, 1'b0, 34));
    wait_result("p7_dmin", 0);
    @(negedge clk);

    // Start while busy is ignored; start in the DONE cycle is accepted.
    issue(-77, 5, mk(-15, -2, 1'b0, 34));
    wait_result("ignore_busy", 10);
    issue(9, 2, mk(4, 1, 1'b0, 34));
    wait_result("b2b_p9_d2", 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(a, b, model(a, b));
      wait_result("random", 0);
    end
    @(negedge clk);

    // Abort an in-flight operation with reset in cycle 15.
    dividend = 100; divisor = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_div_zero", div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    issue(100, 7, mk(14, 2, 1'b0, 34));
    wait_result("after_abort", 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
